hex_to_sseg: RTL and testbench



---
 rtl/hex_to_sseg_if.sv | 17 +
 rtl/hex_to_sseg.sv | 59 +++++
 tb/tb_hex_to_sseg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hex_to_sseg_if.sv
// Digit-in / segments-out bundle between the display scanner and one decoder.
interface hex_to_sseg_if;
  logic [3:0] x;  // hex digit to display
  logic [6:0] r;  // segment pattern {g,f,e,d,c,b,a}

  // Scanner side: supplies the digit, reads back the pattern.
  modport master (
    output x,
    input  r
  );

  // Decoder side.
  modport slave (
    input  x,
    output r
  );
endinterface

// File: rtl/hex_to_sseg.sv
// Registered hex-digit to seven-segment decoder for one display digit.
// The pattern is produced one clock after the digit is sampled. The output register
// powers up blank, so the block works even if it is never reset.
module hex_to_sseg #(
  parameter bit ACTIVE_LOW = 1'b1  // 1: lit segment drives 0 (common-anode board)
) (
  input  logic   clk,
  input  logic   reset,
  hex_to_sseg_if.slave bus
);

  // All segments dark in the selected polarity.
  localparam logic [6:0] Blank = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] seg_low;  // active-low glyph for the current digit
  logic [6:0] r_d;
  logic [6:0] r_q = Blank;

  // Glyph table in active-low form; b and d are lowercase so they differ from 8 and 0.
  always_comb begin
    seg_low = 7'h7F;
    unique case (bus.x)
      4'h0: seg_low = 7'h40;
      4'h1: seg_low = 7'h79;
      4'h2: seg_low = 7'h24;
      4'h3: seg_low = 7'h30;
      4'h4: seg_low = 7'h19;
      4'h5: seg_low = 7'h12;
      4'h6: seg_low = 7'h02;
      4'h7: seg_low = 7'h78;
      4'h8: seg_low = 7'h00;
      4'h9: seg_low = 7'h10;
      4'hA: seg_low = 7'h08;
      4'hB: seg_low = 7'h03;
      4'hC: seg_low = 7'h46;
      4'hD: seg_low = 7'h21;
      4'hE: seg_low = 7'h06;
      4'hF: seg_low = 7'h0E;
      default: seg_low = 7'h7F;
    endcase
  end

  // Apply output polarity.
  always_comb begin
    r_d = ACTIVE_LOW ? seg_low : ~seg_low;
  end

  // Output register; reset blanks the digit and overrides x.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= Blank;
    end else begin
      r_q <= r_d;
    end
  end

  assign bus.r = r_q;

endmodule

// File: tb/tb_hex_to_sseg.sv
// Bench for hex_to_sseg: both polarities side by side, a glyph-level model checked every
// cycle, and directed vectors with literal expected patterns.
module tb_hex_to_sseg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] x_drv = 4'h8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_to_sseg_if bus_lo ();
  hex_to_sseg_if bus_hi ();

  assign bus_lo.x = x_drv;
  assign bus_hi.x = x_drv;

  hex_to_sseg #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lo)
  );

  hex_to_sseg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi)
  );

  // Lit segments per digit, by segment letter.
  string glyph [16] = '{
    "abcdef", "bc",    "abdeg", "abcdg", "bcfg",  "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  // Mask of lit segments (1 = lit) for a digit.
  function automatic logic [6:0] lit(input logic [3:0] d);
    logic [6:0] m;
    string s;
    m = 7'h00;
    s = glyph[d];
    for (int i = 0; i < s.len(); i++) begin
      m[int'(s[i]) - 97] = 1'b1;
    end
    return m;
  endfunction

  // Model: outputs expected after the most recent edge, starting blank.
  logic [6:0] exp_lo = 7'h7F;
  logic [6:0] exp_hi = 7'h00;

  always @(posedge clk) begin
    if (reset) begin
      exp_lo <= 7'h7F;
      exp_hi <= 7'h00;
    end else begin
      exp_lo <= ~lit(x_drv);
      exp_hi <= lit(x_drv);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (bus_lo.r !== exp_lo) begin
      failures++;
      $display("FAIL model_lo t=%0t got=%02h want=%02h", $time, bus_lo.r, exp_lo);
    end
    checks++;
    if (bus_hi.r !== exp_hi) begin
      failures++;
      $display("FAIL model_hi t=%0t got=%02h want=%02h", $time, bus_hi.r, exp_hi);
    end
  end

  task automatic check_lit(input string name, input logic [6:0] want_lo,
                           input logic [6:0] want_hi);
    checks++;
    if (bus_lo.r !== want_lo) begin
      failures++;
      $display("FAIL %s_lo got=%02h want=%02h", name, bus_lo.r, want_lo);
    end
    checks++;
    if (bus_hi.r !== want_hi) begin
      failures++;
      $display("FAIL %s_hi got=%02h want=%02h", name, bus_hi.r, want_hi);
    end
  endtask

  // Drive one cycle of inputs, then check the pattern visible after the edge.
  task automatic step(input logic rst, input logic [3:0] x, input string name,
                      input logic [6:0] want_lo);
    @(negedge clk);
    reset = rst;
    x_drv = x;
    @(posedge clk);
    #1;
    check_lit(name, want_lo, ~want_lo & 7'h7F);
  endtask

  logic [6:0] table_lo [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  initial begin
    // Power-up value before any edge.
    #1;
    check_lit("powerup", 7'h7F, 7'h00);

    // Reset held two cycles with x=8, then released.
    step(1'b1, 4'h8, "reset1", 7'h7F);
    step(1'b1, 4'h8, "reset2", 7'h7F);
    step(1'b0, 4'h8, "release", 7'h00);

    // Exhaustive sweep.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), "sweep", table_lo[i]);
    end

    // Pin the model itself to literal values in both polarities.
    checks++;
    if (lit(4'h0) !== 7'h3F) begin
      failures++;
      $display("FAIL model_pin0 got=%02h want=3f", lit(4'h0));
    end
    checks++;
    if (lit(4'hF) !== 7'h71) begin
      failures++;
      $display("FAIL model_pinF got=%02h want=71", lit(4'hF));
    end

    // Latency: 1 then 2.
    step(1'b0, 4'h1, "lat1", 7'h79);
    step(1'b0, 4'h2, "lat2", 7'h24);

    // Mid-stream reset on the cycle x=5, release with x=6.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'(i), "pre_rst", table_lo[i]);
    end
    step(1'b1, 4'h5, "mid_rst", 7'h7F);
    step(1'b0, 4'h6, "post_rst", 7'h02);

    // Active-high polarity spot values (checked through want_hi = ~want_lo).
    step(1'b0, 4'h0, "pol0", 7'h40);
    step(1'b0, 4'h8, "pol8", 7'h00);
    step(1'b0, 4'hF, "polF", 7'h0E);

    // Wrap-around.
    step(1'b0, 4'hF, "wrapF", 7'h0E);
    step(1'b0, 4'h0, "wrap0", 7'h40);
    step(1'b0, 4'hF, "wrapF2", 7'h0E);

    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
